// File: rtl/pattern_switch_ctrl_if.sv
// Control/status bundle between the pattern switch controller and the DDR source mux.
// master = controller side, slave = mux/register side.
interface pattern_switch_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             pattern_req;
   logic             burst_active;
   logic             conv_empty_in;
   logic             conv_empty_out;
   logic             pattern_en;
   logic             pattern_flush;
   logic             switching;
   logic [CNT_W-1:0] switch_cnt;
   logic             timeout_err;

   modport master (
      input  pattern_req, burst_active, conv_empty_in,
      output conv_empty_out, pattern_en, pattern_flush, switching, switch_cnt, timeout_err
   );

   modport slave (
      output pattern_req, burst_active, conv_empty_in,
      input  conv_empty_out, pattern_en, pattern_flush, switching, switch_cnt, timeout_err
   );
endinterface

// File: rtl/pattern_switch_ctrl.sv
// DIGIFIFO/PATTERN source sequencer: switches only between DDR bursts, then blanks empty for HOLDOFF cycles.
// Registered outputs except conv_empty_out; SWITCH_TIMEOUT_EN adds a DRAIN watchdog that forces the commit.
module pattern_switch_ctrl #(
   parameter int HOLDOFF = 4,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   pattern_switch_ctrl_if.master bus
);
   localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF - 1);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, BLANK = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             pattern_en_q, pattern_en_d;
   logic             pattern_flush_q, pattern_flush_d;
   logic             switching_q, switching_d;
   logic [CNT_W-1:0] switch_cnt_q, switch_cnt_d;
   logic [7:0]       hold_cnt_q, hold_cnt_d;
   logic             commit;
   logic             force_commit;
   logic             conv_empty;

   always_comb begin
      state_d         = state_q;
      pattern_en_d    = pattern_en_q;
      pattern_flush_d = 1'b0;
      switch_cnt_d    = switch_cnt_q;
      hold_cnt_d      = hold_cnt_q;
      commit          = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.pattern_req != pattern_en_q) state_d = DRAIN;
         end
         DRAIN: begin
            // A request that reverts before the burst ends is an abort, not a switch.
            if (bus.pattern_req == pattern_en_q) state_d = RUN;
            else if (!bus.burst_active || force_commit) commit = 1'b1;
         end
         BLANK: begin
            if (hold_cnt_q == 8'd0) state_d = RUN;
            else hold_cnt_d = hold_cnt_q - 1'b1;
         end
         default: state_d = RUN;
      endcase
      if (commit) begin
         state_d         = BLANK;
         pattern_en_d    = ~pattern_en_q;
         pattern_flush_d = pattern_en_q;
         hold_cnt_d      = HOLD_INIT;
         if (switch_cnt_q != {CNT_W{1'b1}}) switch_cnt_d = switch_cnt_q + 1'b1;
      end
      switching_d = (state_d != RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= RUN;
         pattern_en_q    <= 1'b0;
         pattern_flush_q <= 1'b0;
         switching_q     <= 1'b0;
         switch_cnt_q    <= '0;
         hold_cnt_q      <= 8'd0;
      end else begin
         state_q         <= state_d;
         pattern_en_q    <= pattern_en_d;
         pattern_flush_q <= pattern_flush_d;
         switching_q     <= switching_d;
         switch_cnt_q    <= switch_cnt_d;
         hold_cnt_q      <= hold_cnt_d;
      end
   end

`ifdef SWITCH_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout_err_q, timeout_err_d;

   always_comb begin
      to_cnt_d = '0;
      if (state_q == DRAIN) to_cnt_d = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + 1'b1;
      force_commit = (state_q == DRAIN) && (to_cnt_q == TO_LAST) && bus.burst_active;
      // A commit with the burst still live can only be the forced one.
      timeout_err_d = timeout_err_q | (commit & bus.burst_active);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.timeout_err = timeout_err_q;
`else
   logic unused_timeout;
   assign unused_timeout  = (TIMEOUT == 0);
   assign force_commit    = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   always_comb begin
      conv_empty = 1'b1;
      if (!reset) begin
         case (state_q)
            RUN:     conv_empty = bus.conv_empty_in;
            DRAIN:   conv_empty = bus.conv_empty_in | ~bus.burst_active;
            default: conv_empty = 1'b1;
         endcase
      end
   end

   assign bus.conv_empty_out = conv_empty;
   assign bus.pattern_en     = pattern_en_q;
   assign bus.pattern_flush  = pattern_flush_q;
   assign bus.switching      = switching_q;
   assign bus.switch_cnt     = switch_cnt_q;
endmodule
